// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Host-side SPI master for the SPI-slave + single-port RAM block. One parallel
//   command becomes one SS_n-framed serial transaction, one bit per clk cycle:
//   SS_n falls, then one command-check bit (frame[9]), then frame[9:0] MSB
//   first. A read-data command (op 11) then waits RD_GAP cycles and shifts in
//   an 8-bit reply from MISO, which is returned with a one-cycle rsp_valid.
//   Every frame ends with at least GAP_CYC cycles of SS_n high.
//
// Ports
//   clk, rst_n           system clock, async active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op[1:0]          00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   cmd_data[7:0]        address/data byte (sent as 0 for op 11)
//   rsp_valid            one-cycle strobe, rsp_data holds the read byte
//   rsp_data[7:0]        last byte captured from MISO
//   busy                 high whenever not IDLE
//   SS_n, MOSI, MISO     serial interface
//   seq_err              only with SPI_RAM_MASTER_SEQ_CHECK_EN: pulses the
//                        cycle after an op 11 is accepted without a preceding
//                        op 10
//
// Parameters
//   RD_GAP  (1..15)  turnaround cycles between last MOSI bit and first MISO sample
//   GAP_CYC (1..15)  minimum SS_n-high cycles between frames
//
// Optional feature macro: SPI_RAM_MASTER_SEQ_CHECK_EN

module spi_ram_master #(
  parameter int unsigned RD_GAP  = 2,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  output logic       seq_err,
`endif
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEL     = 3'd1,
    TX      = 3'd2,
    WAIT_RD = 3'd3,
    RX      = 3'd4,
    GAP     = 3'd5
  } state_t;

  localparam logic [3:0] RD_LAST  = 4'(RD_GAP - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic       rd_q, rd_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       accept;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // frame_q is shifted left during TX so MOSI always comes from bit 9; the
  // read/no-read decision is therefore kept in rd_q rather than in frame_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    rx_sh_d     = rx_sh_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    SS_n        = 1'b1;
    MOSI        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = (cmd_op == 2'b11) ? {2'b11, 8'h00} : {cmd_op, cmd_data};
          rd_d    = (cmd_op == 2'b11);
          cnt_d   = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        SS_n    = 1'b0;
        MOSI    = frame_q[9];
        cnt_d   = '0;
        state_d = TX;
      end
      TX: begin
        SS_n    = 1'b0;
        MOSI    = frame_q[9];
        frame_d = {frame_q[8:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = rd_q ? WAIT_RD : GAP;
        end
      end
      WAIT_RD: begin
        SS_n  = 1'b0;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = RX;
        end
      end
      RX: begin
        SS_n    = 1'b0;
        rx_sh_d = {rx_sh_q[5:0], MISO};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          rsp_data_d  = {rx_sh_q, MISO};
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      rd_q        <= 1'b0;
      rx_sh_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      rx_sh_q     <= rx_sh_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  logic rd_addr_set_q, rd_addr_set_d;
  logic seq_err_q, seq_err_d;

  always_comb begin
    rd_addr_set_d = rd_addr_set_q;
    seq_err_d     = 1'b0;
    if (accept) begin
      if (cmd_op == 2'b10) begin
        rd_addr_set_d = 1'b1;
      end else if (cmd_op == 2'b11) begin
        seq_err_d     = !rd_addr_set_q;
        rd_addr_set_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_set_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      rd_addr_set_q <= rd_addr_set_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed self-checking bench for spi_ram_master (RD_GAP=2, GAP_CYC=1).
// All inputs are driven and all outputs sampled on the falling clock edge.

module tb_spi_ram_master;

  localparam int RD_GAP  = 2;
  localparam int GAP_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  logic       seq_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  spi_ram_master #(.RD_GAP(RD_GAP), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    .seq_err   (seq_err),
`endif
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Sends one command and follows the frame to its end. exp_mosi holds the
  // 11 bits seen while SS_n is low (check bit first, in the MSB).
  task automatic run_frame(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input logic [7:0] miso_byte, input logic [10:0] exp_mosi,
                           input int exp_len, input logic exp_rsp, input logic [7:0] exp_rdata,
                           input logic exp_seq);
    int k, wait_cyc, rsp_cnt, bad_hs, extra, seq_cnt, seq_at1, rx_first, rx_last;
    logic [10:0] mosi;
    k = 0; wait_cyc = 0; rsp_cnt = 0; bad_hs = 0; extra = 0; seq_cnt = 0; seq_at1 = 0;
    mosi = '0;
    rx_first = 12 + RD_GAP;
    rx_last  = 19 + RD_GAP;
    @(negedge clk);
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!cmd_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'b01; cmd_data = 8'hFF;   // changes mid-frame must have no effect
    while (SS_n == 1'b0 && k < 60) begin
      k++;
      if (k <= 11) mosi = {mosi[9:0], MOSI};
      else if (MOSI) extra++;
      if (cmd_ready || !busy) bad_hs++;
      if (rsp_valid) rsp_cnt++;
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
      if (seq_err) begin
        seq_cnt++;
        if (k == 1) seq_at1 = 1;
      end
`endif
      if (op == 2'b11 && k >= rx_first && k <= rx_last) MISO = miso_byte[rx_last - k];
      else MISO = 1'b1;   // MISO must be ignored outside RX
      @(negedge clk);
    end
    MISO = 1'b0;
    check({tag, "_len"}, k, exp_len);
    check({tag, "_mosi"}, mosi, exp_mosi);
    check({tag, "_mosi_tail"}, extra, 0);
    check({tag, "_ready_busy"}, bad_hs, 0);
    check({tag, "_rsp_in_frame"}, rsp_cnt, 0);
    check({tag, "_rsp_valid"}, rsp_valid, exp_rsp);
    check({tag, "_rsp_data"}, rsp_data, exp_rdata);
    check({tag, "_gap_ready"}, cmd_ready, 1'b0);
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    if (seq_err) seq_cnt++;
    check({tag, "_seq"}, {seq_at1[0], seq_cnt[3:0]}, exp_seq ? 5'b1_0001 : 5'b0_0000);
`else
    check({tag, "_seq_unused"}, exp_seq, exp_seq);
`endif
    @(negedge clk);
    check({tag, "_rsp_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int k, frames, lo_run, hi_run, hi_min, hi_max, lo_bad, hs_bad, accepts, cyc;
    logic prev_ss;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_ss", SS_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", {SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    // Write address, write data, read address, read data
    run_frame("wa",  2'b00, 8'hA5, 8'h00, 11'h0A5, 11, 1'b0, 8'h00, 1'b0);
    run_frame("wd",  2'b01, 8'h3C, 8'h00, 11'h13C, 11, 1'b0, 8'h00, 1'b0);
    run_frame("ra",  2'b10, 8'hA5, 8'h00, 11'h6A5, 11, 1'b0, 8'h00, 1'b0);
    run_frame("rd",  2'b11, 8'hFF, 8'h3C, 11'h700, 19 + RD_GAP, 1'b1, 8'h3C, 1'b0);

    // Back-to-back: cmd_valid held over three frames
    frames = 0; lo_run = 0; hi_run = 0; hi_min = 99; hi_max = 0;
    lo_bad = 0; hs_bad = 0; accepts = 0; cyc = 0;
    @(negedge clk);
    cmd_op = 2'b00; cmd_data = 8'hC3; cmd_valid = 1'b1;
    prev_ss = SS_n;
    while (frames < 3 && cyc < 100) begin
      if (cmd_ready) accepts++;
      if (!SS_n && cmd_ready) hs_bad++;
      if (!SS_n) lo_run++;
      else hi_run++;
      @(negedge clk);
      cyc++;
      if (prev_ss && !SS_n) begin
        if (accepts > 1) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
        end
        hi_run = 0;
      end
      if (!prev_ss && SS_n) begin
        frames++;
        if (lo_run != 11) lo_bad++;
        lo_run = 0;
        hi_run = 0;
      end
      prev_ss = SS_n;
    end
    cmd_valid = 1'b0;
    check("b2b_frames", frames, 3);
    check("b2b_accepts", accepts, 3);
    check("b2b_len", lo_bad, 0);
    check("b2b_ready_low", hs_bad, 0);
    check("b2b_gap_min", hi_min, GAP_CYC + 1);
    check("b2b_gap_max", hi_max, GAP_CYC + 1);
    repeat (3) @(negedge clk);

    // Reset during RX cycle 4 of a read-data frame
    cmd_op = 2'b11; cmd_data = 8'h00; cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (k < 15 + RD_GAP && !SS_n) begin
      MISO = 1'b1;
      @(negedge clk);
      k++;
    end
    check("mid_in_rx", {SS_n, busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {SS_n, busy, cmd_ready, rsp_valid}, 4'b1010);
    MISO = 1'b0;
    k = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || !SS_n) k++;
    end
    check("mid_no_rsp", k, 0);
    check("mid_rsp_data", rsp_data, 8'h00);
    run_frame("post", 2'b00, 8'h5A, 8'h00, 11'h05A, 11, 1'b0, 8'h00, 1'b0);

    // Read-sequence checking (seq_err observed only when the feature is built)
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame("sq_rd0", 2'b11, 8'h00, 8'h96, 11'h700, 19 + RD_GAP, 1'b1, 8'h96, 1'b1);
    run_frame("sq_ra",  2'b10, 8'h11, 8'h00, 11'h611, 11, 1'b0, 8'h96, 1'b0);
    run_frame("sq_rd1", 2'b11, 8'h00, 8'h4B, 11'h700, 19 + RD_GAP, 1'b1, 8'h4B, 1'b0);
    run_frame("sq_rd2", 2'b11, 8'h00, 8'hE7, 11'h700, 19 + RD_GAP, 1'b1, 8'hE7, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
